// File: rtl/step_seq_pkg.sv
// Shared types for the step sequencer: FSM state encoding and a small state helper.
package step_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSTF = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/step_seq_table.sv
// DEPTH-entry {level, dwell} register file: one synchronous write port, one async read port.
module step_seq_table
  import step_seq_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_level,
  input  logic [DWELL_W-1:0]      wr_dwell,
  input  logic [AW-1:0]           rd_idx,
  output logic signed [WIDTH-1:0] rd_level,
  output logic [DWELL_W-1:0]      rd_dwell
);

  typedef struct packed {
    logic signed [WIDTH-1:0] level;
    logic [DWELL_W-1:0]      dwell;
  } step_t;

  step_t mem_r [DEPTH];

  // Table storage; cleared on reset so a fresh run outputs zero levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[wr_addr] <= '{level: wr_level, dwell: wr_dwell};
    end
  end

  assign rd_level = mem_r[rd_idx].level;
  assign rd_dwell = mem_r[rd_idx].dwell;

endmodule

// File: rtl/step_seq_ctrl.sv
// Table-driven staircase stimulus sequencer with timed filter reset and busy/done handshake.
// Optional macro STEP_SEQ_LOOP_EN adds a 'loop' input for continuous cycling until abort.
module step_seq_ctrl
  import step_seq_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16,
  parameter int RST_CYC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(DEPTH)-1:0]     cfg_addr,
  input  logic signed [WIDTH-1:0]      cfg_level,
  input  logic [DWELL_W-1:0]           cfg_dwell,
  input  logic [$clog2(DEPTH):0]       cfg_len,
  input  logic                         start,
  input  logic                         abort,
`ifdef STEP_SEQ_LOOP_EN
  input  logic                         loop,
`endif
  output logic signed [WIDTH-1:0]      v_in_o,
  output logic                         filt_rst,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH)-1:0]     step_idx
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;

  state_t                  state_r, state_nxt_s;
  logic [DWELL_W-1:0]      cnt_r, cnt_nxt_s;
  logic [AW-1:0]           idx_r, idx_nxt_s;
  logic [LEN_W-1:0]        len_r, len_nxt_s;
  logic                    loop_r, loop_nxt_s;
  logic                    load_rst_s, load_dwell_s, dec_s, last_s, loop_req_s;
  logic signed [WIDTH-1:0] rd_level_s;
  logic [DWELL_W-1:0]      rd_dwell_s;
  logic signed [WIDTH-1:0] v_in_r;
  logic                    filt_rst_r, busy_r, done_r;

`ifdef STEP_SEQ_LOOP_EN
  assign loop_req_s = loop;
`else
  assign loop_req_s = 1'b0;
`endif

  // The table is read at the next index so the registered level lines up with the new step.
  step_seq_table #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DWELL_W(DWELL_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we && !busy_r),
    .wr_addr (cfg_addr),
    .wr_level(cfg_level),
    .wr_dwell(cfg_dwell),
    .rd_idx  (idx_nxt_s),
    .rd_level(rd_level_s),
    .rd_dwell(rd_dwell_s)
  );

  assign last_s = ({1'b0, idx_r} == (len_r - LEN_W'(1)));

  // Next-state, step index and run-parameter latching; abort outranks counter expiry.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    len_nxt_s    = len_r;
    loop_nxt_s   = loop_r;
    load_rst_s   = 1'b0;
    load_dwell_s = 1'b0;
    dec_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RSTF;
          idx_nxt_s   = '0;
          len_nxt_s   = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
          loop_nxt_s  = loop_req_s;
          load_rst_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RSTF: begin
        if (abort) begin
          state_nxt_s = FIN;
        end else if (cnt_r == DWELL_W'(1)) begin
          if (len_r == '0) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s  = RUN;
            idx_nxt_s    = '0;
            load_dwell_s = 1'b1;
          end
        end else begin
          dec_s = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = FIN;
        end else if (cnt_r == DWELL_W'(1)) begin
          if (!last_s) begin
            idx_nxt_s    = idx_r + AW'(1);
            load_dwell_s = 1'b1;
          end else if (loop_r) begin
            idx_nxt_s    = '0;
            load_dwell_s = 1'b1;
          end else begin
            state_nxt_s = FIN;
          end
        end else begin
          dec_s = 1'b1;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Shared down-counter: RSTF length, then per-step dwell with zero promoted to one.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load_dwell_s) begin
      cnt_nxt_s = (rd_dwell_s == '0) ? DWELL_W'(1) : rd_dwell_s;
    end else if (load_rst_s) begin
      cnt_nxt_s = DWELL_W'(RST_CYC);
    end else if (dec_s) begin
      cnt_nxt_s = cnt_r - DWELL_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      len_r      <= '0;
      loop_r     <= 1'b0;
      v_in_r     <= '0;
      filt_rst_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      len_r      <= len_nxt_s;
      loop_r     <= loop_nxt_s;
      v_in_r     <= (state_nxt_s == RUN) ? rd_level_s : '0;
      filt_rst_r <= (state_nxt_s == RSTF);
      busy_r     <= is_busy(state_nxt_s);
      done_r     <= (state_nxt_s == FIN);
    end
  end

  assign v_in_o   = v_in_r;
  assign filt_rst = filt_rst_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign step_idx = idx_r;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Scoreboard bench for step_seq_ctrl: expected per-cycle output frames are queued
// when a run is launched and popped/compared every cycle on the falling edge.
module tb_step_seq_ctrl;

  localparam int WIDTH   = 18;
  localparam int DEPTH   = 8;
  localparam int DWELL_W = 16;
  localparam int RST_CYC = 4;

  logic                     clk;
  logic                     rst;
  logic                     cfg_we;
  logic [2:0]               cfg_addr;
  logic signed [WIDTH-1:0]  cfg_level;
  logic [DWELL_W-1:0]       cfg_dwell;
  logic [3:0]               cfg_len;
  logic                     start;
  logic                     abort;
`ifdef STEP_SEQ_LOOP_EN
  logic                     loop_in;
`endif
  logic signed [WIDTH-1:0]  v_in_o;
  logic                     filt_rst;
  logic                     busy;
  logic                     done;
  logic [2:0]               step_idx;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic             fr;
    logic             bsy;
    logic             dn;
    logic [2:0]       idx;
  } frame_t;

  frame_t exp_q[$];
  int     lvl_m[DEPTH];
  int     dw_m[DEPTH];
  int     checks   = 0;
  int     failures = 0;

  step_seq_ctrl #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DWELL_W(DWELL_W),
    .RST_CYC(RST_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_level(cfg_level),
    .cfg_dwell(cfg_dwell),
    .cfg_len  (cfg_len),
    .start    (start),
    .abort    (abort),
`ifdef STEP_SEQ_LOOP_EN
    .loop     (loop_in),
`endif
    .v_in_o   (v_in_o),
    .filt_rst (filt_rst),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_v_in"},     {14'd0, v_in_o}, 32'd0);
    check_eq({tag, "_filt_rst"}, {31'd0, filt_rst}, 32'd1);
    check_eq({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"},     {31'd0, done}, 32'd0);
    check_eq({tag, "_step_idx"}, {29'd0, step_idx}, 32'd0);
  endtask

  task automatic cfg_write(input int a, input int lvl, input int dw);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_level = 18'(lvl);
    cfg_dwell = 16'(dw);
    @(negedge clk);
    cfg_we = 1'b0;
    lvl_m[a] = lvl;
    dw_m[a]  = dw;
  endtask

  // Expected frames from the cycle after the start edge through one idle cycle after FIN.
  task automatic build(input int len, input int abort_n, input bit lp);
    int  i;
    bit  fin;
    logic [2:0] last_idx;
    for (int r = 0; r < RST_CYC; r++) exp_q.push_back('{18'd0, 1'b1, 1'b1, 1'b0, 3'd0});
    if (len > 0) begin
      i   = 0;
      fin = 1'b0;
      while (!fin) begin
        for (int c = 0; c < ((dw_m[i] == 0) ? 1 : dw_m[i]); c++)
          exp_q.push_back('{18'(lvl_m[i]), 1'b0, 1'b1, 1'b0, 3'(i)});
        i++;
        if (i == len) begin
          if (lp) i = 0;
          else fin = 1'b1;
        end
        if (abort_n >= 0 && exp_q.size() >= abort_n) fin = 1'b1;
        if (exp_q.size() > 1000) fin = 1'b1;
      end
    end
    if (abort_n >= 0) begin
      while (exp_q.size() > abort_n) void'(exp_q.pop_back());
    end
    last_idx = exp_q[$].idx;
    exp_q.push_back('{18'd0, 1'b0, 1'b1, 1'b1, last_idx});
    exp_q.push_back('{18'd0, 1'b0, 1'b0, 1'b0, last_idx});
  endtask

  // Launch a run; abort during frame abort_n-1, attempt a table write during frame wr_at,
  // stop comparing after stop_n frames (negative values disable each feature).
  task automatic do_run(input string name, input int len, input int abort_n, input int wr_at,
                        input int stop_n, input bit lp);
    frame_t e;
    int     n;
    build(len, abort_n, lp);
    @(negedge clk);
    cfg_len = 4'(len);
    start   = 1'b1;
`ifdef STEP_SEQ_LOOP_EN
    loop_in = lp;
`endif
    n = 0;
    while (exp_q.size() > 0 && (stop_n < 0 || n < stop_n)) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      check_eq($sformatf("%s_v_in[%0d]", name, n),     {14'd0, v_in_o},   {14'd0, e.v});
      check_eq($sformatf("%s_filt_rst[%0d]", name, n), {31'd0, filt_rst}, {31'd0, e.fr});
      check_eq($sformatf("%s_busy[%0d]", name, n),     {31'd0, busy},     {31'd0, e.bsy});
      check_eq($sformatf("%s_done[%0d]", name, n),     {31'd0, done},     {31'd0, e.dn});
      check_eq($sformatf("%s_step_idx[%0d]", name, n), {29'd0, step_idx}, {29'd0, e.idx});
      abort = (n == abort_n - 1);
      if (n == wr_at) begin
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_level = 18'sd49152;
        cfg_dwell = 16'd9;
      end else begin
        cfg_we = 1'b0;
      end
      n++;
    end
    abort  = 1'b0;
    cfg_we = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_level = '0; cfg_dwell = '0;
    cfg_len = '0; start = 1'b0; abort = 1'b0;
`ifdef STEP_SEQ_LOOP_EN
    loop_in = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      lvl_m[i] = 0;
      dw_m[i]  = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Q2.16: 0.5 = 32768, -0.25 = -16384, 1.0 = 65536
    cfg_write(0, 32768, 3);
    cfg_write(1, -16384, 2);
    cfg_write(2, 65536, 5);
    do_run("basic", 3, -1, -1, -1, 1'b0);
    do_run("len0", 0, -1, -1, -1, 1'b0);

    cfg_write(1, -16384, 0);
    do_run("dwell0", 3, -1, -1, -1, 1'b0);
    cfg_write(1, -16384, 2);

    do_run("abort_run", 3, 9, -1, -1, 1'b0);
    do_run("after_abort", 3, -1, -1, -1, 1'b0);
    do_run("abort_rstf", 3, 2, -1, -1, 1'b0);

    do_run("busy_write", 3, -1, 6, -1, 1'b0);
    do_run("after_write", 3, -1, -1, -1, 1'b0);

    do_run("pre_reset", 3, -1, -1, 10, 1'b0);
    #1 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("held_rst");
    end
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      lvl_m[i] = 0;
      dw_m[i]  = 0;
    end
    do_run("zeroed", 3, -1, -1, -1, 1'b0);

`ifdef STEP_SEQ_LOOP_EN
    cfg_write(0, 1000, 2);
    cfg_write(1, -2000, 3);
    do_run("loop", 2, RST_CYC + 16, -1, -1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
